// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and fetch-state encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

  localparam logic Stop    = 1'b1;
  localparam logic NotStop = 1'b0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DONE  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// RV32I fetch stage: assembles a 32-bit instruction from four byte reads and
// presents it to IF/ID, redirecting on EX branches and draining a lost byte read.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [5:0]             stall,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   mem_req_o,
  output logic [InstAddrBus-1:0] mem_addr_o,
  input  logic                   mem_valid_i,
  input  logic [7:0]             mem_data_i,
  output logic                   stallreq_o,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst
);

  fetch_state_e           state_reg, state_next;
  logic [InstAddrBus-1:0] pc_reg, pc_next;
  logic [1:0]             cnt_reg, cnt_next;
  logic [23:0]            buf_reg, buf_next;
  logic [InstBus-1:0]     inst_reg, inst_next;

  // Only stall[0] concerns the fetch stage.
  logic stall_unused;
  assign stall_unused = ^stall[5:1];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      cnt_reg   <= 2'd0;
      buf_reg   <= 24'd0;
      inst_reg  <= ZeroWord;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      buf_reg   <= buf_next;
      inst_reg  <= inst_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    buf_next   = buf_reg;
    inst_next  = inst_reg;
    case (state_reg)
      FETCH: begin
        if (branch_flag_i) begin
          // A request is latched by the controller on its first cycle, so
          // without a same-cycle return the byte is still owed and must drain.
          pc_next    = branch_target_i;
          cnt_next   = 2'd0;
          state_next = mem_valid_i ? FETCH : DRAIN;
        end else if (mem_valid_i) begin
          if (cnt_reg == 2'd3) begin
            inst_next  = {mem_data_i, buf_reg};
            state_next = DONE;
          end else begin
            buf_next[{cnt_reg, 3'b000} +: 8] = mem_data_i;
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end
      DONE: begin
        if (branch_flag_i) begin
          pc_next    = branch_target_i;
          cnt_next   = 2'd0;
          state_next = FETCH;
        end else if (stall[0] == NotStop) begin
          pc_next    = pc_reg + 32'd4;
          cnt_next   = 2'd0;
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (branch_flag_i) begin
          pc_next = branch_target_i;
        end
        // Leave on the owed byte even if a branch lands on the same cycle,
        // otherwise nothing would ever release the stage.
        if (mem_valid_i) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
        cnt_next   = 2'd0;
      end
    endcase
  end

  // Request/stall lines are forced low while reset is asserted.
  assign mem_req_o  = rst_in && (state_reg == FETCH);
  assign stallreq_o = rst_in && (state_reg != DONE);
  assign mem_addr_o = pc_reg + {30'd0, cnt_reg};
  assign if_pc      = (state_reg == DONE) ? pc_reg   : ZeroWord;
  assign if_inst    = (state_reg == DONE) ? inst_reg : ZeroWord;

endmodule

// File: tb/tb_if_fetch.sv
// Directed test of if_fetch against a small byte-wide memory-controller model.
module tb_if_fetch;

  logic        clk_in;
  logic        rst_in;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [7:0]  mem_data_i;
  logic        stallreq_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int total = 0;
  int bad   = 0;

  logic [31:0] addr_q[$];
  int          lat = 1;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_valid_i     (mem_valid_i),
    .mem_data_i      (mem_data_i),
    .stallreq_o      (stallreq_o),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0010_0513;
      32'h0000_0004: mem_word = 32'h0020_0593;
      32'h0000_0008: mem_word = 32'h0030_0613;
      32'h0000_0040: mem_word = 32'h0bad_c0de;
      32'h0000_0100: mem_word = 32'hdead_beef;
      32'h0000_0104: mem_word = 32'h1122_3344;
      32'h0000_0200: mem_word = 32'hcafe_f00d;
      default:       mem_word = 32'ha5a5_a5a5;
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    mem_byte = w[{a[1:0], 3'b000} +: 8];
  endfunction

  // True when addr_q[start..start+n-1] is base, base+1, ... (modulo 2^32).
  function automatic bit q_is_run(input logic [31:0] base, input int start, input int n);
    q_is_run = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (addr_q[start+i] !== base + 32'(i)) q_is_run = 1'b0;
    end
  endfunction

  // Controller model: latches one request, returns the byte lat edges later.
  initial begin : controller
    logic [31:0] held_addr;
    int          cd;
    bit          busy;
    mem_valid_i = 1'b0;
    mem_data_i  = 8'h00;
    busy        = 1'b0;
    cd          = 0;
    held_addr   = 32'h0;
    forever begin
      @(posedge clk_in);
      #1;
      mem_valid_i = 1'b0;
      if (!rst_in) begin
        busy = 1'b0;
      end else if (busy) begin
        cd--;
        if (cd <= 0) begin
          mem_valid_i = 1'b1;
          mem_data_i  = mem_byte(held_addr);
          busy        = 1'b0;
        end
      end else if (mem_req_o) begin
        held_addr = mem_addr_o;
        addr_q.push_back(mem_addr_o);
        busy = 1'b1;
        cd   = lat;
      end
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (rst_in && !stallreq_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_qsize(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (addr_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    rst_in = 1'b0; stall = 6'd0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    repeat (2) @(negedge clk_in);
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rst_stallreq got=%b want=0", stallreq_o); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_if_pc got=%h want=0", if_pc); end
    total++; if (if_inst !== 32'h0) begin bad++; $display("FAIL rst_if_inst got=%h want=0", if_inst); end
    addr_q.delete();
    rst_in = 1'b1;
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL t1_timeout got=no_done want=done"); end
    total++; if (addr_q.size() != 4 || !q_is_run(32'h0, 0, 4)) begin
      bad++; $display("FAIL t1_addr_seq got_n=%0d first=%h want=00000000..00000003", addr_q.size(), addr_q[0]);
    end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL t1_if_pc got=%h want=00000000", if_pc); end
    total++; if (if_inst !== 32'h0010_0513) begin bad++; $display("FAIL t1_if_inst got=%h want=00100513", if_inst); end
    @(negedge clk_in);
    total++; if (stallreq_o !== 1'b1 || mem_req_o !== 1'b1) begin
      bad++; $display("FAIL t1_one_cycle_done got=stallreq%b/req%b want=1/1", stallreq_o, mem_req_o);
    end
    total++; if (mem_addr_o !== 32'h4) begin bad++; $display("FAIL t1_next_addr got=%h want=00000004", mem_addr_o); end
    total++; if (if_inst !== 32'h0) begin bad++; $display("FAIL t1_bubble got=%h want=00000000", if_inst); end
    $display("test_reset: fetched 0x0, next addr %h", mem_addr_o);
  endtask

  task automatic test_stall;
    bit ok;
    stall = 6'b000001;
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL t2_timeout got=no_done want=done"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      total++; if (if_pc !== 32'h4 || if_inst !== 32'h0020_0593 || mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
        bad++; $display("FAIL t2_hold cyc=%0d got=pc%h inst%h req%b sreq%b want=pc00000004 inst00200593 req0 sreq0",
                        i, if_pc, if_inst, mem_req_o, stallreq_o);
      end
    end
    stall = 6'd0;
    @(negedge clk_in);
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin
      bad++; $display("FAIL t2_release got=req%b addr%h want=req1 addr00000008", mem_req_o, mem_addr_o);
    end
    $display("test_stall: held 3 cycles, next addr %h", mem_addr_o);
  endtask

  task automatic test_branch_done;
    bit ok;
    stall = 6'b000001;
    wait_done(ok);
    total++; if (!ok || if_inst !== 32'h0030_0613 || if_pc !== 32'h8) begin
      bad++; $display("FAIL t3_pre got=pc%h inst%h want=pc00000008 inst00300613", if_pc, if_inst);
    end
    addr_q.delete();
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    @(negedge clk_in);
    branch_flag_i = 1'b0;
    total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      bad++; $display("FAIL t3_redirect got=req%b addr%h want=req1 addr00000100", mem_req_o, mem_addr_o);
    end
    wait_done(ok);
    total++; if (!ok || if_pc !== 32'h100 || if_inst !== 32'hdead_beef) begin
      bad++; $display("FAIL t3_result got=pc%h inst%h want=pc00000100 instdeadbeef", if_pc, if_inst);
    end
    total++; if (addr_q.size() != 4 || !q_is_run(32'h100, 0, 4)) begin
      bad++; $display("FAIL t3_addr_seq got_n=%0d first=%h want=00000100..00000103", addr_q.size(), addr_q[0]);
    end
    $display("test_branch_done: pc=%h inst=%h", if_pc, if_inst);
  endtask

  task automatic test_drain;
    bit ok;
    lat = 3;
    addr_q.delete();
    stall = 6'd0;
    @(negedge clk_in);
    stall = 6'b000001;
    wait_qsize(3, ok);
    total++; if (!ok || addr_q[2] !== 32'h106) begin
      bad++; $display("FAIL t4_pre got=addr%h want=00000106", addr_q[2]);
    end
    branch_flag_i = 1'b1; branch_target_i = 32'h200;
    @(negedge clk_in);
    branch_flag_i = 1'b0;
    total++; if (mem_req_o !== 1'b0 || stallreq_o !== 1'b1 || if_inst !== 32'h0) begin
      bad++; $display("FAIL t4_drain got=req%b sreq%b inst%h want=req0 sreq1 inst00000000", mem_req_o, stallreq_o, if_inst);
    end
    wait_done(ok);
    total++; if (!ok || if_pc !== 32'h200 || if_inst !== 32'hcafe_f00d) begin
      bad++; $display("FAIL t4_result got=pc%h inst%h want=pc00000200 instcafef00d", if_pc, if_inst);
    end
    total++; if (addr_q.size() != 7 || !q_is_run(32'h104, 0, 3) || !q_is_run(32'h200, 3, 4)) begin
      bad++; $display("FAIL t4_addr_seq got_n=%0d q3=%h want=104..106,200..203", addr_q.size(), addr_q[3]);
    end
    lat = 1;
    $display("test_drain: pc=%h inst=%h", if_pc, if_inst);
  endtask

  task automatic test_branch_on_valid;
    bit ok;
    addr_q.delete();
    stall = 6'd0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (addr_q.size() == 4 && mem_valid_i) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) begin bad++; $display("FAIL t5_timeout got=no_4th_valid want=4th_valid"); end
    branch_flag_i = 1'b1; branch_target_i = 32'h40;
    @(negedge clk_in);
    branch_flag_i = 1'b0;
    stall = 6'b000001;
    total++; if (if_inst !== 32'h0 || stallreq_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin
      bad++; $display("FAIL t5_no_done got=inst%h sreq%b req%b addr%h want=inst00000000 sreq1 req1 addr00000040",
                      if_inst, stallreq_o, mem_req_o, mem_addr_o);
    end
    wait_done(ok);
    total++; if (!ok || if_pc !== 32'h40 || if_inst !== 32'h0bad_c0de) begin
      bad++; $display("FAIL t5_result got=pc%h inst%h want=pc00000040 inst0badc0de", if_pc, if_inst);
    end
    total++; if (addr_q.size() != 8 || !q_is_run(32'h204, 0, 4) || !q_is_run(32'h40, 4, 4)) begin
      bad++; $display("FAIL t5_addr_seq got_n=%0d q4=%h want=204..207,40..43", addr_q.size(), addr_q[4]);
    end
    $display("test_branch_on_valid: pc=%h inst=%h", if_pc, if_inst);
  endtask

  task automatic test_reset_mid_fetch;
    bit ok;
    addr_q.delete();
    stall = 6'd0;
    @(negedge clk_in);
    stall = 6'b000001;
    wait_qsize(2, ok);
    total++; if (!ok || addr_q[1] !== 32'h45) begin
      bad++; $display("FAIL t6_pre got=addr%h want=00000045", addr_q[1]);
    end
    rst_in = 1'b0;
    #1;
    total++; if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      bad++; $display("FAIL t6_async got=req%b sreq%b pc%h inst%h want=all_zero", mem_req_o, stallreq_o, if_pc, if_inst);
    end
    repeat (2) @(negedge clk_in);
    addr_q.delete();
    rst_in = 1'b1;
    wait_done(ok);
    total++; if (!ok || if_pc !== 32'h0 || if_inst !== 32'h0010_0513) begin
      bad++; $display("FAIL t6_result got=pc%h inst%h want=pc00000000 inst00100513", if_pc, if_inst);
    end
    total++; if (addr_q.size() != 4 || !q_is_run(32'h0, 0, 4)) begin
      bad++; $display("FAIL t6_addr_seq got_n=%0d first=%h want=00000000..00000003", addr_q.size(), addr_q[0]);
    end
    $display("test_reset_mid_fetch: restarted at %h", if_pc);
  endtask

  task automatic test_wrap;
    bit ok;
    addr_q.delete();
    branch_flag_i = 1'b1; branch_target_i = 32'hffff_fffe;
    @(negedge clk_in);
    branch_flag_i = 1'b0;
    wait_done(ok);
    total++; if (!ok || if_pc !== 32'hffff_fffe || if_inst !== 32'h0513_a5a5) begin
      bad++; $display("FAIL t7_result got=pc%h inst%h want=pcfffffffe inst0513a5a5", if_pc, if_inst);
    end
    total++; if (addr_q.size() != 4 || !q_is_run(32'hffff_fffe, 0, 4)) begin
      bad++; $display("FAIL t7_addr_seq got_n=%0d q2=%h want=fffffffe,ffffffff,0,1", addr_q.size(), addr_q[2]);
    end
    stall = 6'd0;
    @(negedge clk_in);
    total++; if (mem_addr_o !== 32'h2 || mem_req_o !== 1'b1) begin
      bad++; $display("FAIL t7_pc_wrap got=req%b addr%h want=req1 addr00000002", mem_req_o, mem_addr_o);
    end
    $display("test_wrap: next addr %h", mem_addr_o);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch_done();
    test_drain();
    test_branch_on_valid();
    test_reset_mid_fetch();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and fetches each 32-bit instruction as four little-endian bytes over the byte-wide memory-controller port.
- Presents if_pc/if_inst to IF/ID and raises a stall request to the pipeline controller until the instruction is complete.
- Handles branch redirects from EX, including draining an in-flight byte request.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset and fetched first after reset release.

Ports:
clk_in  input  1  system clock, rising edge.
rst_in  input  1  asynchronous, active-low reset.
stall  input  6  pipeline stall vector from controller; stall[0]=`Stop holds the PC.
branch_flag_i  input  1  EX redirect request, valid for one cycle.
branch_target_i  input  32  redirect target PC.
mem_req_o  output  1  byte read request to memory controller.
mem_addr_o  output  32  byte address of the request.
mem_valid_i  input  1  requested byte is returned this cycle.
mem_data_i  input  8  returned byte.
stallreq_o  output  1  fetch incomplete; controller must stall stages 0-1.
if_pc  output  32  PC of the presented instruction.
if_inst  output  32  assembled instruction.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - pc=RESET_PC, cnt=0, state=FETCH, byte buffer=0.
  - Outputs held at 0: mem_req_o=0, stallreq_o=0, if_pc=0, if_inst=0.
- States: FETCH, DONE, DRAIN. 2-bit byte counter cnt; 24-bit buffer for bytes 0..2.
- FETCH:
  - mem_req_o=1; mem_addr_o=pc+cnt (32-bit add, wraps modulo 2^32).
  - Request held stable until mem_valid_i.
  - Only one byte is ever outstanding.
- On mem_valid_i in FETCH with cnt<3: store mem_data_i at byte lane cnt; cnt<=cnt+1.
- On mem_valid_i in FETCH with cnt==3:
  - if_inst <= {mem_data_i, buf[23:0]}; if_pc <= pc; state<=DONE.
  - Latency: 4 valid handshakes. With a 1-cycle-latency controller, if_inst is registered at the 4th valid edge.
- DONE:
  - mem_req_o=0, stallreq_o=0, if_pc/if_inst stable.
  - If stall[0]=`NotStop: pc<=pc+4, cnt<=0, state<=FETCH, same edge. IF/ID captures the instruction on that edge.
  - If stall[0]=`Stop: hold in DONE with outputs unchanged.
- stallreq_o=1 in FETCH and DRAIN (combinational from state); 0 in DONE and during reset.
- if_pc and if_inst are 0 whenever state!=DONE, so the bubble inserted into IF/ID is deterministic.
- Branch (branch_flag_i=1) takes priority over stall[0] and over byte capture:
  - DONE: pc<=target, cnt<=0, state<=FETCH.
  - FETCH with mem_valid_i same cycle: discard byte, pc<=target, cnt<=0, stay FETCH.
  - FETCH, no valid, request already issued in an earlier cycle: pc<=target, cnt<=0, state<=DRAIN.
  - FETCH first cycle of a request (not yet issued): treated as issued, goes to DRAIN. The controller latches requests on the first cycle.
  - DRAIN: mem_req_o=0. The next mem_valid_i is dropped, then state<=FETCH at the saved pc.
  - A branch during DRAIN overwrites the saved pc and stays in DRAIN.
- Boundary cases:
  - PC near 2^32: pc+cnt and pc+4 wrap silently.
  - Misaligned branch targets are fetched as given; no exception.
  - mem_valid_i in DONE (spurious): ignored.
- Reset mid-fetch aborts immediately; no drain is performed. The controller is reset by the same rst_in.

Decomposition:
- Shared defines: InstAddrBus, InstBus, ZeroWord, Stop/NotStop.
- Add FetchStateBus and state encodings (FETCH=2'd0, DONE=2'd1, DRAIN=2'd2) to the shared defines.
- Single module; no sub-module is natural, since byte assembly and the PC are tightly coupled to the FSM.

Test Plan:
1. Reset release, memory at 0x0 holds 13 05 10 00, 1-cycle valid latency, stall=0:
   - mem_addr_o sequences 0,1,2,3.
   - Then DONE with if_pc=0, if_inst=32'h00100513, stallreq_o=0 for one cycle.
   - Next fetch starts at 0x4.
2. stall[0]=1 held 3 cycles while in DONE: if_pc/if_inst stable, mem_req_o=0. Release -> next request addr=pc+4.
3. branch_flag_i=1, target=0x100, in DONE: next mem_addr_o=0x100. The instruction assembled there appears with if_pc=0x100.
4. Branch to 0x200 at cnt=2 with byte request outstanding, valid 3 cycles later:
   - DRAIN with mem_req_o=0; that byte is dropped.
   - Then requests 0x200..0x203; if_inst built only from those bytes.
5. Branch coinciding with mem_valid_i at cnt=3 (target 0x40): no DONE occurs, if_inst stays 0, next addr=0x40.
6. rst_in pulsed low mid-fetch (cnt=1): all outputs 0 asynchronously. After release, fetch restarts at RESET_PC with cnt=0.
